// File: rtl/uart_conf_tx_pkg.sv
// Shared definitions for the configuration UART pair (receiver and transmitter):
// line-format constants, default timing and the state encodings.
package uart_conf_tx_pkg;

    // Defaults: 1 MHz clock, 9600 baud, four parameter bytes per report frame
    localparam int unsigned BAUD_DIV_DEF     = 104;
    localparam int unsigned CONF_PAR_MAX_DEF = 4;
    localparam logic [7:0]  HDR_DEF          = 8'hA5;

    // 8N1: start + 8 data + stop
    localparam int unsigned FRAME_BITS = 10;

    // Per-byte serialiser states
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Frame sequencer states
    typedef enum logic {
        F_IDLE,
        F_SEND
    } frame_state_t;

    // Running checksum step; 8-bit accumulate wraps modulo 256
    function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. Owns the baud counter and the START/DATA/STOP sequence.
// ready is high while idle and during the last cycle of the stop bit, so a
// load presented in that cycle starts the next start bit with no gap.
module uart_tx_byte
    import uart_conf_tx_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int unsigned      CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BAUD_DIV - 2);

    if (BAUD_DIV < 2 || BAUD_DIV > 65535) begin : g_bad_baud
        $error("uart_tx_byte: BAUD_DIV out of range 2..65535");
    end

    tx_state_t        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    // Serialiser FSM: every line level is held for exactly BAUD_DIV cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            ready    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx    <= 1'b1;
                    ready <= 1'b1;
                    if (load) begin
                        shreg    <= data;
                        baud_cnt <= '0;
                        tx       <= 1'b0;
                        ready    <= 1'b0;
                        state    <= START;
                    end
                end

                START: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // shreg[0] is always the bit on the line; shift to expose the next
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[1];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (load) begin
                            shreg <= data;
                            tx    <= 1'b0;
                            ready <= 1'b0;
                            state <= START;
                        end else begin
                            tx    <= 1'b1;
                            ready <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                        if (baud_cnt == CNT_PRE) begin
                            ready <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_conf_tx.sv
// Configuration/status report transmitter. On send it snapshots the parameter
// bytes and emits HDR, par 0..CONF_PAR_MAX-1, CHK as back-to-back 8N1 bytes.
// CHK is the modulo-256 sum of the parameter bytes only.
module uart_conf_tx
    import uart_conf_tx_pkg::*;
#(
    parameter int unsigned BAUD_DIV     = BAUD_DIV_DEF,
    parameter int unsigned CONF_PAR_MAX = CONF_PAR_MAX_DEF,
    parameter logic [7:0]  HDR          = HDR_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      send,
    input  logic [CONF_PAR_MAX*8-1:0] par_in,
    output logic                      tx,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned      IDX_W    = $clog2(CONF_PAR_MAX + 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CONF_PAR_MAX + 1);
    localparam logic [IDX_W-1:0] IDX_CHK  = IDX_W'(CONF_PAR_MAX);

    if (CONF_PAR_MAX < 1 || CONF_PAR_MAX > 255) begin : g_bad_par
        $error("uart_conf_tx: CONF_PAR_MAX out of range 1..255");
    end

    frame_state_t     state;
    logic [IDX_W-1:0] byte_idx;
    logic [7:0]       snap [CONF_PAR_MAX];
    logic [7:0]       chk;
    logic [7:0]       next_par;
    logic             byte_load;
    logic [7:0]       byte_data;
    logic             byte_ready;

    // Parameter byte following the one currently on the line (byte_idx counts HDR as 0)
    always_comb begin
        next_par = '0;
        for (int unsigned k = 0; k < CONF_PAR_MAX; k++) begin
            if (byte_idx == IDX_W'(k)) begin
                next_par = snap[k];
            end
        end
    end

    // Feed the serialiser: HDR on acceptance, then each following byte in its final stop cycle
    always_comb begin
        byte_load = 1'b0;
        byte_data = HDR;
        case (state)
            F_IDLE: begin
                byte_load = send;
                byte_data = HDR;
            end
            F_SEND: begin
                if (byte_ready && byte_idx != IDX_LAST) begin
                    byte_load = 1'b1;
                    byte_data = (byte_idx == IDX_CHK) ? chk : next_par;
                end
            end
            default: begin
                byte_load = 1'b0;
                byte_data = HDR;
            end
        endcase
    end

    // Frame sequencer: snapshot, byte index, running checksum, busy/done
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= F_IDLE;
            byte_idx <= '0;
            chk      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                F_IDLE: begin
                    if (send) begin
                        for (int unsigned k = 0; k < CONF_PAR_MAX; k++) begin
                            snap[k] <= par_in[8*k +: 8];
                        end
                        chk      <= '0;
                        byte_idx <= '0;
                        busy     <= 1'b1;
                        state    <= F_SEND;
                    end
                end
                F_SEND: begin
                    if (byte_ready) begin
                        if (byte_idx == IDX_LAST) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= F_IDLE;
                        end else begin
                            // checksum absorbs each parameter byte as it is handed over
                            if (byte_idx != IDX_CHK) begin
                                chk <= chk_add(chk, next_par);
                            end
                            byte_idx <= byte_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= F_IDLE;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx_byte (
        .clk   (clk),
        .rst   (rst),
        .load  (byte_load),
        .data  (byte_data),
        .tx    (tx),
        .ready (byte_ready)
    );

endmodule
